// File: rtl/snake_body_engine.sv
// ============================================================================
// Module   : snake_body_engine
// Brief    : Snake head/body engine with circular position buffer, occupancy
//            bitmap, growth, wall/self collision and a registered cell query.
//            Optional macro SNAKE_WRAP_EN makes the board edges wrap around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_body_engine #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   s_dir,
    input  logic                         tick,
    input  logic                         grow,
    input  logic [$clog2(GRID_W)-1:0]    q_x,
    input  logic [$clog2(GRID_H)-1:0]    q_y,
    output logic                         q_hit,
    output logic                         q_head,
    output logic [$clog2(GRID_W)-1:0]    head_x,
    output logic [$clog2(GRID_H)-1:0]    head_y,
    output logic [$clog2(MAX_LEN):0]     length,
    output logic                         game_over
);

    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int PW    = $clog2(MAX_LEN);
    localparam int LW    = PW + 1;
    localparam int IW    = XW + YW;
    localparam int CELLS = GRID_W * GRID_H;

    localparam logic [XW-1:0] c_X_ONE  = XW'(1);
    localparam logic [XW-1:0] c_X_MAX  = XW'(GRID_W - 1);
    localparam logic [XW-1:0] c_X_INIT = XW'(GRID_W / 2);
    localparam logic [YW-1:0] c_Y_ONE  = YW'(1);
    localparam logic [YW-1:0] c_Y_MAX  = YW'(GRID_H - 1);
    localparam logic [YW-1:0] c_Y_INIT = YW'(GRID_H / 2);
    localparam logic [PW-1:0] c_P_ONE  = PW'(1);
    localparam logic [PW-1:0] c_HP_INIT = PW'(INIT_LEN - 1);
    localparam logic [LW-1:0] c_LEN_ONE  = LW'(1);
    localparam logic [LW-1:0] c_LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0] c_LEN_INIT = LW'(INIT_LEN);

    // Bitmap is indexed {y, x}, i.e. y*GRID_W + x since GRID_W is a power of two.
    function automatic logic [CELLS-1:0] f_init_occ();
        logic [CELLS-1:0] v;
        v = '0;
        for (int i = 0; i < INIT_LEN; i++) begin
            v[(GRID_H / 2 + i) * GRID_W + GRID_W / 2] = 1'b1;
        end
        return v;
    endfunction

    // Slot 0 holds the tail, slot INIT_LEN-1 the head.
    function automatic logic [YW-1:0] f_init_by(int i);
        if (i < INIT_LEN) begin
            return YW'(GRID_H / 2 + INIT_LEN - 1 - i);
        end
        return '0;
    endfunction

    localparam logic [CELLS-1:0] c_INIT_OCC = f_init_occ();

    typedef enum logic [0:0] {
        S_PLAY = 1'b0,
        S_DEAD = 1'b1
    } state_t;

    state_t             r_state;
    logic [XW-1:0]      r_head_x;
    logic [YW-1:0]      r_head_y;
    logic [PW-1:0]      r_hp;
    logic [PW-1:0]      r_tp;
    logic [LW-1:0]      r_length;
    logic               r_pending;
    logic               r_game_over;
    logic               r_q_hit;
    logic               r_q_head;
    logic [CELLS-1:0]   r_occ;
    logic [XW-1:0]      r_buf_x [MAX_LEN];
    logic [YW-1:0]      r_buf_y [MAX_LEN];

    logic [XW-1:0]      w_nx;
    logic [YW-1:0]      w_ny;
    logic               w_wall;
    logic [IW-1:0]      w_nidx;
    logic [IW-1:0]      w_tidx;
    logic [IW-1:0]      w_qidx;
    logic               w_grow_now;
    logic               w_vacate;
    logic               w_self;
    logic               w_try;
    logic               w_move;
    logic               w_crash;
    logic [PW-1:0]      w_hp_next;
    logic [XW-1:0]      w_hx_next;
    logic [YW-1:0]      w_hy_next;
    logic [CELLS-1:0]   w_occ_next;

    // Power-of-two board: plain modular add/subtract already yields the wrapped cell.
    always_comb begin
        w_nx = r_head_x;
        w_ny = r_head_y;
        case (s_dir)
            2'b00:   w_ny = r_head_y - c_Y_ONE;
            2'b01:   w_nx = r_head_x - c_X_ONE;
            2'b10:   w_nx = r_head_x + c_X_ONE;
            default: w_ny = r_head_y + c_Y_ONE;
        endcase
    end

    always_comb begin
`ifdef SNAKE_WRAP_EN
        w_wall = 1'b0;
`else
        case (s_dir)
            2'b00:   w_wall = (r_head_y == '0);
            2'b01:   w_wall = (r_head_x == '0);
            2'b10:   w_wall = (r_head_x == c_X_MAX);
            default: w_wall = (r_head_y == c_Y_MAX);
        endcase
`endif
    end

    assign w_nidx     = {w_ny, w_nx};
    assign w_tidx     = {r_buf_y[r_tp], r_buf_x[r_tp]};
    assign w_qidx     = {q_y, q_x};
    assign w_grow_now = r_pending && (r_length < c_LEN_MAX);
    assign w_vacate   = !w_grow_now;
    // The tail cell is legal to enter only when it is being vacated on this move.
    assign w_self     = r_occ[w_nidx] && !(w_vacate && (w_nidx == w_tidx));
    assign w_try      = (r_state == S_PLAY) && tick;
    assign w_move     = w_try && !w_wall && !w_self;
    assign w_crash    = w_try && (w_wall || w_self);
    assign w_hp_next  = r_hp + c_P_ONE;
    assign w_hx_next  = w_move ? w_nx : r_head_x;
    assign w_hy_next  = w_move ? w_ny : r_head_y;

    // Clear before set so a head stepping onto the vacating tail stays occupied.
    always_comb begin
        w_occ_next = r_occ;
        if (w_move) begin
            if (w_vacate) begin
                w_occ_next[w_tidx] = 1'b0;
            end
            w_occ_next[w_nidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_PLAY;
            r_head_x    <= c_X_INIT;
            r_head_y    <= c_Y_INIT;
            r_hp        <= c_HP_INIT;
            r_tp        <= '0;
            r_length    <= c_LEN_INIT;
            r_pending   <= 1'b0;
            r_game_over <= 1'b0;
            r_q_hit     <= 1'b0;
            r_q_head    <= 1'b0;
            r_occ       <= c_INIT_OCC;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_buf_x[i] <= c_X_INIT;
                r_buf_y[i] <= f_init_by(i);
            end
        end else begin
            r_occ    <= w_occ_next;
            r_q_hit  <= w_occ_next[w_qidx];
            r_q_head <= (w_qidx == {w_hy_next, w_hx_next});
            case (r_state)
                S_PLAY: begin
                    if (w_crash) begin
                        r_state     <= S_DEAD;
                        r_game_over <= 1'b1;
                    end else if (w_move) begin
                        r_head_x           <= w_nx;
                        r_head_y           <= w_ny;
                        r_hp               <= w_hp_next;
                        r_buf_x[w_hp_next] <= w_nx;
                        r_buf_y[w_hp_next] <= w_ny;
                        if (w_vacate) begin
                            r_tp <= r_tp + c_P_ONE;
                        end else begin
                            r_length <= r_length + c_LEN_ONE;
                        end
                        r_pending <= grow;
                    end else if (grow) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_DEAD;
                end
            endcase
        end
    end

    assign q_hit     = r_q_hit;
    assign q_head    = r_q_head;
    assign head_x    = r_head_x;
    assign head_y    = r_head_y;
    assign length    = r_length;
    assign game_over = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_snake_body_engine.sv
// ============================================================================
// Module   : tb_snake_body_engine
// Brief    : Directed and random checks of snake_body_engine against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_body_engine;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int ML = 32;
    localparam int IL = 3;

    logic       clk = 1'b0;
    logic       reset, tick, grow;
    logic [1:0] s_dir;
    logic [3:0] q_x, q_y;
    logic       q_hit, q_head, game_over;
    logic [3:0] head_x, head_y;
    logic [5:0] length;

    logic       sm_reset, sm_tick, sm_grow;
    logic [1:0] sm_dir;
    logic [3:0] sm_qx, sm_qy;
    logic       sm_q_hit, sm_q_head, sm_game_over;
    logic [3:0] sm_head_x, sm_head_y;
    logic [2:0] sm_length;

    int n_assert = 0;
    int n_fail   = 0;

    int mx[$];
    int my[$];
    bit m_pend;
    bit m_dead;

    always #5 clk = ~clk;

    snake_body_engine #(.GRID_W(W), .GRID_H(H), .MAX_LEN(ML), .INIT_LEN(IL)) dut (
        .clk(clk), .reset(reset), .s_dir(s_dir), .tick(tick), .grow(grow),
        .q_x(q_x), .q_y(q_y), .q_hit(q_hit), .q_head(q_head),
        .head_x(head_x), .head_y(head_y), .length(length), .game_over(game_over)
    );

    snake_body_engine #(.GRID_W(W), .GRID_H(H), .MAX_LEN(4), .INIT_LEN(3)) dut_small (
        .clk(clk), .reset(sm_reset), .s_dir(sm_dir), .tick(sm_tick), .grow(sm_grow),
        .q_x(sm_qx), .q_y(sm_qy), .q_hit(sm_q_hit), .q_head(sm_q_head),
        .head_x(sm_head_x), .head_y(sm_head_y), .length(sm_length), .game_over(sm_game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        mx.delete();
        my.delete();
        for (int i = 0; i < IL; i++) begin
            mx.push_back(W / 2);
            my.push_back(H / 2 + i);
        end
        m_pend = 1'b0;
        m_dead = 1'b0;
    endfunction

    function automatic bit m_occ(input int x, input int y);
        for (int i = 0; i < mx.size(); i++) begin
            if (mx[i] == x && my[i] == y) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Snake as a head-first list of cells; a move prepends and optionally drops the last.
    function automatic void m_move(input int dir);
        int nx, ny;
        bit hit, vacate;
        nx = mx[0];
        ny = my[0];
        case (dir)
            0: ny = ny - 1;
            1: nx = nx - 1;
            2: nx = nx + 1;
            default: ny = ny + 1;
        endcase
        hit = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
`ifdef SNAKE_WRAP_EN
        hit = 1'b0;
        nx  = (nx + W) % W;
        ny  = (ny + H) % H;
`endif
        vacate = !(m_pend && mx.size() < ML);
        for (int i = 0; i < mx.size(); i++) begin
            if (!(vacate && i == mx.size() - 1) && mx[i] == nx && my[i] == ny) hit = 1'b1;
        end
        if (hit) begin
            m_dead = 1'b1;
            return;
        end
        mx.push_front(nx);
        my.push_front(ny);
        if (vacate) begin
            void'(mx.pop_back());
            void'(my.pop_back());
        end
        m_pend = 1'b0;
    endfunction

    function automatic void m_step(input bit rst, input int dir, input bit tk, input bit gr);
        if (rst) begin
            m_reset();
        end else if (!m_dead) begin
            if (tk) begin
                m_move(dir);
                if (!m_dead && gr) m_pend = 1'b1;
            end else if (gr) begin
                m_pend = 1'b1;
            end
        end
    endfunction

    // Drive one cycle from a negedge, update the model at the posedge, check at the next negedge.
    task automatic step(input bit rst, input int dir, input bit tk, input bit gr,
                        input int qx, input int qy);
        reset = rst;
        s_dir = 2'(dir);
        tick  = tk;
        grow  = gr;
        q_x   = 4'(qx);
        q_y   = 4'(qy);
        @(posedge clk);
        m_step(rst, dir, tk, gr);
        @(negedge clk);
        chk("head_x", 32'(head_x), 32'(mx[0]));
        chk("head_y", 32'(head_y), 32'(my[0]));
        chk("length", 32'(length), 32'(mx.size()));
        chk("game_over", 32'(game_over), 32'(m_dead));
        chk("q_hit", 32'(q_hit), rst ? 32'd0 : 32'(m_occ(qx, qy)));
        chk("q_head", 32'(q_head), rst ? 32'd0 : 32'(qx == mx[0] && qy == my[0]));
    endtask

    task automatic sstep(input bit rst, input int dir, input bit tk, input bit gr,
                         input int qx, input int qy);
        sm_reset = rst;
        sm_dir   = 2'(dir);
        sm_tick  = tk;
        sm_grow  = gr;
        sm_qx    = 4'(qx);
        sm_qy    = 4'(qy);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int dir;
        reset = 1'b1; tick = 1'b0; grow = 1'b0; s_dir = 2'd0; q_x = '0; q_y = '0;
        sm_reset = 1'b1; sm_tick = 1'b0; sm_grow = 1'b0; sm_dir = 2'd0; sm_qx = '0; sm_qy = '0;
        m_reset();
        @(negedge clk);

        step(1, 0, 0, 0, 8, 8);
        step(0, 0, 0, 0, 8, 8);
        chk("init_q_hit_88", 32'(q_hit), 32'd1);
        chk("init_q_head_88", 32'(q_head), 32'd1);
        step(0, 0, 0, 0, 8, 9);
        step(0, 0, 0, 0, 8, 10);
        chk("init_q_hit_810", 32'(q_hit), 32'd1);
        step(0, 0, 0, 0, 8, 11);
        chk("init_q_hit_811", 32'(q_hit), 32'd0);
        chk("init_length", 32'(length), 32'd3);

        step(0, 0, 1, 0, 8, 10);
        chk("up1_head_y", 32'(head_y), 32'd7);
        chk("up1_tail_freed", 32'(q_hit), 32'd0);

        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8, i);
        chk("up8_head_y", 32'(head_y), 32'd0);
        chk("up8_game_over", 32'(game_over), 32'd0);
        step(0, 0, 1, 0, 8, 0);
`ifdef SNAKE_WRAP_EN
        chk("up9_head_y", 32'(head_y), 32'd15);
        chk("up9_game_over", 32'(game_over), 32'd0);
`else
        chk("up9_head_y", 32'(head_y), 32'd0);
        chk("up9_game_over", 32'(game_over), 32'd1);
`endif
        step(0, 2, 1, 1, 8, 0);
        step(0, 2, 1, 0, 8, 0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 2, 1, 0, 8, 10);
        chk("grow_head_x", 32'(head_x), 32'd9);
        chk("grow_length", 32'(length), 32'd4);
        chk("grow_tail_kept", 32'(q_hit), 32'd1);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("same_cycle_len1", 32'(length), 32'd3);
        step(0, 0, 1, 0, 0, 0);
        chk("same_cycle_len2", 32'(length), 32'd4);

        step(1, 0, 0, 0, 0, 0);
        step(0, 3, 1, 0, 8, 9);
        chk("neck_game_over", 32'(game_over), 32'd1);
        chk("neck_length", 32'(length), 32'd3);
        step(1, 0, 0, 0, 8, 8);
        chk("rst_dead_go", 32'(game_over), 32'd0);
        chk("rst_dead_x", 32'(head_x), 32'd8);

        sstep(1, 0, 0, 0, 0, 0);
        sstep(0, 0, 0, 1, 0, 0);
        sstep(0, 2, 1, 0, 8, 10);
        chk("sm_len_a", 32'(sm_length), 32'd4);
        chk("sm_hit_a", 32'(sm_q_hit), 32'd1);
        sstep(0, 0, 0, 1, 0, 0);
        sstep(0, 2, 1, 0, 8, 10);
        chk("sm_len_b", 32'(sm_length), 32'd4);
        chk("sm_head_b", 32'(sm_head_x), 32'd10);
        chk("sm_tail_freed", 32'(sm_q_hit), 32'd0);
        sstep(0, 0, 0, 0, 8, 9);
        chk("sm_body_kept", 32'(sm_q_hit), 32'd1);
        chk("sm_game_over", 32'(sm_game_over), 32'd0);

        step(1, 0, 0, 0, 0, 0);
        dir = 0;
        for (int n = 0; n < 3000; n++) begin
            int qx, qy;
            if ($urandom_range(3) == 0) dir = int'($urandom_range(3));
            if ($urandom_range(1) == 0) begin
                qx = int'($urandom_range(W - 1));
                qy = int'($urandom_range(H - 1));
            end else begin
                qx = (mx[0] + int'($urandom_range(2)) - 1 + W) % W;
                qy = (my[0] + int'($urandom_range(2)) - 1 + H) % H;
            end
            step((m_dead && $urandom_range(3) == 0) || $urandom_range(499) == 0,
                 dir, $urandom_range(1) == 1, $urandom_range(5) == 0, qx, qy);
        end
        tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
